// File: rtl/vehicle_detect_cond.sv
// Vehicle detection conditioner: each direction synchronizes its raw loop
// sensor, debounces it and counts debounced arrivals while its own green is off.
// A green lamp flushes that direction's waiting-vehicle count.

// One direction: synchronizer, debounce FSM, arrival pulse, saturating queue.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_LOW     | debounced level 0, synchronized input agrees
// ST_CHK_HIGH| debounced level 0, counting consecutive 1 samples
// ST_HIGH    | debounced level 1, synchronized input agrees
// ST_CHK_LOW | debounced level 1, counting consecutive 0 samples
module vdc_lane #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned Q_WIDTH   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sensor,
  input  logic               i_green,
  output logic               o_detect,
  output logic [Q_WIDTH-1:0] o_queue
);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } state_e;

  localparam logic [3:0]         DB_C  = 4'(DB_CYCLES);
  localparam logic [Q_WIDTH-1:0] Q_MAX = '1;

  logic               sync1_q, sync2_q;
  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               arrive_q, arrive_d;
  logic [Q_WIDTH-1:0] queue_q, queue_d;
  logic               detect_q;

  // Two-flop synchronizer for the asynchronous loop sensor.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_sensor;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM state, hold counter and registered arrival pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_LOW;
      cnt_q    <= 4'd0;
      arrive_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arrive_q <= arrive_d;
    end
  end

  // Debounce next-state: a level is accepted after DB_CYCLES matching samples.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arrive_d = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        if (sync2_q) begin
          if (DB_CYCLES == 1) begin
            state_d  = ST_HIGH;
            cnt_d    = 4'd0;
            arrive_d = 1'b1;
          end else begin
            state_d = ST_CHK_HIGH;
            cnt_d   = 4'd1;
          end
        end
      end
      ST_CHK_HIGH: begin
        if (sync2_q) begin
          if (cnt_q + 4'd1 == DB_C) begin
            state_d  = ST_HIGH;
            cnt_d    = 4'd0;
            arrive_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_LOW;
          cnt_d   = 4'd0;
        end
      end
      ST_HIGH: begin
        if (!sync2_q) begin
          if (DB_CYCLES == 1) begin
            state_d = ST_LOW;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_CHK_LOW;
            cnt_d   = 4'd1;
          end
        end
      end
      ST_CHK_LOW: begin
        if (!sync2_q) begin
          if (cnt_q + 4'd1 == DB_C) begin
            state_d = ST_LOW;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_HIGH;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Queue next value: green flushes (and swallows a same-cycle arrival), else saturating count.
  always_comb begin
    queue_d = queue_q;
    if (i_green) begin
      queue_d = '0;
    end else if (arrive_q && (queue_q != Q_MAX)) begin
      queue_d = queue_q + 1'b1;
    end
  end

  // Queue and detect registered together so detect always reflects the stored count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      queue_q  <= '0;
      detect_q <= 1'b0;
    end else begin
      queue_q  <= queue_d;
      detect_q <= (queue_d != '0);
    end
  end

  assign o_queue  = queue_q;
  assign o_detect = detect_q;

endmodule

// Top: two fully independent lanes, one per direction.
module vehicle_detect_cond #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned Q_WIDTH   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ns_sensor,
  input  logic               i_ew_sensor,
  input  logic               i_ns_green,
  input  logic               i_ew_green,
  output logic               o_ns_vehicle_detect,
  output logic               o_ew_vehicle_detect,
  output logic [Q_WIDTH-1:0] o_ns_queue,
  output logic [Q_WIDTH-1:0] o_ew_queue
);

  vdc_lane #(.DB_CYCLES(DB_CYCLES), .Q_WIDTH(Q_WIDTH)) u_ns (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_sensor (i_ns_sensor),
    .i_green  (i_ns_green),
    .o_detect (o_ns_vehicle_detect),
    .o_queue  (o_ns_queue)
  );

  vdc_lane #(.DB_CYCLES(DB_CYCLES), .Q_WIDTH(Q_WIDTH)) u_ew (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_sensor (i_ew_sensor),
    .i_green  (i_ew_green),
    .o_detect (o_ew_vehicle_detect),
    .o_queue  (o_ew_queue)
  );

endmodule

// File: tb/tb_vehicle_detect_cond.sv
// Bench for vehicle_detect_cond: directed scenarios plus random bouncy sensors,
// every cycle compared against a run-length reference model of the behaviour.
module tb_vehicle_detect_cond;

  localparam int DB   = 4;
  localparam int QMAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ns_sensor = 1'b0, ew_sensor = 1'b0;
  logic       ns_green = 1'b0, ew_green = 1'b0;
  logic       ns_det, ew_det;
  logic [3:0] ns_q, ew_q;

  int n_vec = 0;
  int n_err = 0;

  // Reference model, index 0 = NS, 1 = EW.
  int m_d1[2], m_d2[2];   // raw samples one and two edges ago
  int m_lvl[2];           // accepted (debounced) level
  int m_run[2];           // consecutive samples disagreeing with accepted level
  int m_arr[2];           // arrival seen last edge, applied to queue this edge
  int m_q[2];             // waiting-vehicle count

  int hold[2];

  vehicle_detect_cond #(.DB_CYCLES(DB), .Q_WIDTH(4)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_ns_sensor         (ns_sensor),
    .i_ew_sensor         (ew_sensor),
    .i_ns_green          (ns_green),
    .i_ew_green          (ew_green),
    .o_ns_vehicle_detect (ns_det),
    .o_ew_vehicle_detect (ew_det),
    .o_ns_queue          (ns_q),
    .o_ew_queue          (ew_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_d1[l] = 0; m_d2[l] = 0; m_lvl[l] = 0;
      m_run[l] = 0; m_arr[l] = 0; m_q[l] = 0;
    end
  endtask

  task automatic model_edge();
    int raw[2], grn[2], used;
    raw[0] = int'(ns_sensor); raw[1] = int'(ew_sensor);
    grn[0] = int'(ns_green);  grn[1] = int'(ew_green);
    for (int l = 0; l < 2; l++) begin
      used    = m_d2[l];
      m_d2[l] = m_d1[l];
      m_d1[l] = raw[l];
      if (grn[l] != 0)     m_q[l] = 0;
      else if (m_arr[l] != 0) m_q[l] = (m_q[l] < QMAX) ? m_q[l] + 1 : QMAX;
      m_arr[l] = 0;
      if (used != m_lvl[l]) begin
        m_run[l]++;
        if (m_run[l] == DB) begin
          m_lvl[l] = used;
          m_run[l] = 0;
          m_arr[l] = used;
        end
      end else begin
        m_run[l] = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("ns_queue",  {4'd0, ns_q},   8'(m_q[0]));
    chk("ew_queue",  {4'd0, ew_q},   8'(m_q[1]));
    chk("ns_detect", {7'd0, ns_det}, 8'(m_q[0] != 0));
    chk("ew_detect", {7'd0, ew_det}, 8'(m_q[1] != 0));
  endtask

  // One clock: model advances with the inputs the DUT samples, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ns_arrival();
    ns_sensor = 1'b1; steps(DB + 2);
    ns_sensor = 1'b0; steps(DB + 2);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_ns_queue", {4'd0, ns_q},   8'd0);
    chk("reset_ew_queue", {4'd0, ew_q},   8'd0);
    chk("reset_ns_det",   {7'd0, ns_det}, 8'd0);
    chk("reset_ew_det",   {7'd0, ew_det}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Held NS sensor sampled high from edge 10: count appears at edge 16.
    for (int e = 1; e <= 20; e++) begin
      ns_sensor = (e >= 10);
      step();
      if (e == 15) chk("ns_latency_e15", {4'd0, ns_q}, 8'd0);
      if (e == 16) begin
        chk("ns_latency_e16", {4'd0, ns_q}, 8'd1);
        chk("ns_det_e16", {7'd0, ns_det}, 8'd1);
        chk("ew_quiet_e16", {4'd0, ew_q}, 8'd0);
      end
    end
    ns_sensor = 1'b0; steps(10);

    // EW glitch of DB-1 cycles rejected, DB cycles accepted.
    ew_sensor = 1'b1; steps(DB - 1);
    ew_sensor = 1'b0; steps(10);
    chk("ew_short_pulse", {4'd0, ew_q}, 8'd0);
    ew_sensor = 1'b1; steps(DB);
    ew_sensor = 1'b0; steps(10);
    chk("ew_full_pulse", {4'd0, ew_q}, 8'd1);

    // Saturation then flush on NS green.
    for (int a = 0; a < 20; a++) ns_arrival();
    chk("ns_saturate", {4'd0, ns_q}, 8'd15);
    chk("ns_sat_det", {7'd0, ns_det}, 8'd1);
    ns_green = 1'b1; step();
    ns_green = 1'b0;
    chk("ns_green_clear", {4'd0, ns_q}, 8'd0);
    chk("ns_green_det", {7'd0, ns_det}, 8'd0);
    steps(2);

    // Simultaneous arrivals; NS one lands while NS green is on.
    ns_sensor = 1'b1; ew_sensor = 1'b1;
    steps(DB + 2);
    ns_green = 1'b1;
    step();
    ns_green = 1'b0;
    chk("ns_arrival_on_green", {4'd0, ns_q}, 8'd0);
    chk("ew_simul_arrival", {4'd0, ew_q}, 8'd2);
    ns_sensor = 1'b0; ew_sensor = 1'b0; steps(10);

    // Async reset mid-debounce with queue at 5.
    for (int a = 0; a < 5; a++) ns_arrival();
    ns_sensor = 1'b1; steps(3);
    chk("ns_pre_reset", {4'd0, ns_q}, 8'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_ns_queue", {4'd0, ns_q},   8'd0);
    chk("async_ew_queue", {4'd0, ew_q},   8'd0);
    chk("async_ns_det",   {7'd0, ns_det}, 8'd0);
    chk("async_ew_det",   {7'd0, ew_det}, 8'd0);
    model_reset();
    #1 rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 6) chk("resume_e6", {4'd0, ns_q}, 8'd0);
      if (e == 7) chk("resume_e7", {4'd0, ns_q}, 8'd1);
    end
    ns_sensor = 1'b0; steps(10);

    // Random bouncy sensors and occasional greens (including both at once).
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold[0] == 0) begin ns_sensor = ~ns_sensor; hold[0] = $urandom_range(1, 8); end
      if (hold[1] == 0) begin ew_sensor = ~ew_sensor; hold[1] = $urandom_range(1, 8); end
      hold[0]--; hold[1]--;
      ns_green = ($urandom_range(0, 11) == 0);
      ew_green = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
